counter_up_down_mod: RTL
========================

Name: counter_up_down_mod

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Width is generic. The terminal value is programmable at run time, so one instance covers MOD-16, MOD-11 and any MOD-N up to 2^WIDTH.
- Adds enable, synchronous parallel load, direction switching without restart, a terminal-count flag, and a one-shot mode that halts at terminal.
- Used as the general timing/sequence counter in the vector designs.

Parameters:
- WIDTH, 4, counter bit width (minimum 1).
- RESET_VAL, 0, count value after reset (must be <= 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; count advances one step per clk edge while high.
- dir  input  1  0 = up counting, 1 = down counting.
- mod_max  input  WIDTH  top value; count range is 0..mod_max (MOD = mod_max+1).
- one_shot  input  1  0 = wrap at terminal, 1 = stop at terminal and assert done.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value applied on load.
- count  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational: en & ~done & (count at terminal for current dir).
- done  output  1  registered; one-shot terminal reached.

Behaviour:
- Reset (async, rst=1): count=RESET_VAL, done=0, state=RUN. tc=0 while rst is asserted. Reset mid-count takes effect immediately, without waiting for clk.
- Terminal value: mod_max when dir=0; 0 when dir=1.
- Priority per edge: rst > load > en > hold.
- load=1:
  - count <= min(load_val, mod_max); done <= 0; state <= RUN.
  - en is ignored that cycle.
  - Works from DONE.
- State RUN, en=1, up (dir=0):
  - count >= mod_max: at terminal. If one_shot=0, count <= 0. If one_shot=1, count <= mod_max, done <= 1, state <= DONE.
  - Otherwise count <= count+1.
- State RUN, en=1, down (dir=1):
  - count == 0: at terminal. If one_shot=0, count <= mod_max. If one_shot=1, count holds 0, done <= 1, state <= DONE.
  - count > mod_max: count <= mod_max (clamp, not terminal).
  - Otherwise count <= count-1.
- State RUN, en=0: count holds; tc=0.
- State DONE: count and done hold; en and dir are ignored; tc=0. Exit only via load or rst.
- Terminal value is visible for exactly one enabled cycle before the wrap. No skipped or repeated values:
  - up: ...,mod_max,0,...
  - down: ...,1,0,mod_max,...
- Direction change: takes effect at the next enabled edge, stepping from the current count. No reload, no lost cycle.
- mod_max changed mid-count:
  - up with count > mod_max wraps to 0 on the next enabled edge.
  - down clamps as above.
  - tc uses the current mod_max.
- mod_max=0: count stays 0; tc=1 on every enabled RUN cycle. In one-shot mode, done sets on the first enabled edge.
- Arithmetic is modulo 2^WIDTH, but the explicit compares above must prevent any natural overflow from being reached.
- one_shot is sampled each edge. Clearing it while in DONE does not release; load is required.
- No X on outputs after reset for any input sequence.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - State encoding ST_RUN=1'b0, ST_DONE=1'b1.
  - Function clamp(val, max).
- One combinational sub-module, counter_step: inputs count, dir, mod_max; outputs next_count, at_terminal. It contains all wrap/clamp arithmetic.
- The top level holds registers, priority, the FSM and the one-shot logic.

Test Plan (WIDTH=4 unless noted):
- Reset/MOD-16 up: rst pulse, mod_max=15, dir=0, en=1, 18 edges -> count 0..15,0,1. tc high only while count=15. Async rst mid-count forces count=0 before the next edge.
- MOD-11 down wrap: mod_max=10, dir=1, load 10, en=1 -> 10,9,...,0,10,9. tc high only at count=0. Never reaches 11..15.
- Direction switch and enable gating: up to count=6, en=0 for 3 edges (holds at 6), then dir=1, en=1 -> 5,4,3 with no repeated 6.
- One-shot: one_shot=1, mod_max=5, up from 0 -> 0..5 then holds 5, done=1, tc=0. Further en/dir toggles have no effect. load_val=2 -> count=2, done=0, resumes counting.
- Load/clamp and mod_max change: mod_max=7, load_val=12 -> count=7. At count=9 (mod_max=15), set mod_max=4: up -> next count 0; down -> next count 4.
- Width generality and edge case: WIDTH=8 with mod_max=255 up wraps 255->0. WIDTH=4 with mod_max=0 holds count 0 with tc=1 each enabled cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the programmable up/down counter: direction codes,
// FSM state encoding and the load clamp helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // Wide enough for any practical counter width; callers cast in and out.
  localparam int CLAMP_W = 64;

  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] val,
                                               input logic [CLAMP_W-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_up_down_mod_step.sv
// Combinational step: next count and terminal detection for the current
// direction and top value. All wrap/clamp arithmetic lives here.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] next_count,
  output logic             at_terminal
);

  always_comb begin
    next_count  = count;
    at_terminal = 1'b0;
    if (dir == DIR_UP) begin
      // >= so a count stranded above a lowered mod_max wraps instead of overflowing
      if (count >= mod_max) begin
        at_terminal = 1'b1;
        next_count  = '0;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        at_terminal = 1'b1;
        next_count  = mod_max;
      end else if (count > mod_max) begin
        next_count = mod_max;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_up_down_mod.sv
// Programmable MOD-N up/down counter with enable, synchronous load,
// terminal-count flag and a one-shot mode that halts at terminal.
module counter_up_down_mod
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_clamped;
  logic             at_terminal;

  counter_step #(.WIDTH(WIDTH)) u_step (
    .count      (count_q),
    .dir        (dir),
    .mod_max    (mod_max),
    .next_count (step_next),
    .at_terminal(at_terminal)
  );

  assign load_clamped = WIDTH'(clamp(CLAMP_W'(load_val), CLAMP_W'(mod_max)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && en) begin
      if (at_terminal && one_shot) begin
        // Park on the terminal value of the current direction.
        count_d = (dir == DIR_UP) ? mod_max : '0;
        state_d = ST_DONE;
      end else begin
        count_d = step_next;
      end
    end
  end

  assign count = count_q;
  assign done  = (state_q == ST_DONE);
  assign tc    = ~rst & en & (state_q == ST_RUN) & at_terminal;

endmodule
